// File: rtl/mux_n_registrado.sv
// Registered N-channel operand selector with valid/ready handshake.
// Define MUX_VARREDURA_EN to build the round-robin scan mode (Modo/ponteiro).
module mux_n_registrado #(
    parameter int LARGURA = 8,
    parameter int CANAIS  = 4,
    localparam int SEL_W  = $clog2(CANAIS)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [CANAIS*LARGURA-1:0] Entradas,
    input  logic [SEL_W-1:0]          Controle,
    input  logic                      Modo,
    input  logic                      Habilita,
    input  logic                      Pronto,
    output logic [LARGURA-1:0]        Resultado,
    output logic [SEL_W-1:0]          Canal,
    output logic                      Valido,
    output logic                      Erro
);

    function automatic logic [LARGURA-1:0] dado_canal(
        input logic [CANAIS*LARGURA-1:0] ent,
        input logic [SEL_W-1:0]          s
    );
        dado_canal = '0;
        for (int k = 0; k < CANAIS; k++)
            if (s == SEL_W'(k)) dado_canal = ent[k*LARGURA +: LARGURA];
    endfunction

    function automatic logic fora_de_faixa(input logic [SEL_W-1:0] s);
        fora_de_faixa = 1'b1;
        for (int k = 0; k < CANAIS; k++)
            if (s == SEL_W'(k)) fora_de_faixa = 1'b0;
    endfunction

    logic [LARGURA-1:0] resultado_p0;
    logic [SEL_W-1:0]   canal_p0;
    logic               vld_p0;
    logic               erro_p0;
    logic               aceita;
    logic [SEL_W-1:0]   sel;

    // A stalled sample blocks new captures until the consumer takes it
    assign aceita = Habilita && (!vld_p0 || Pronto);

`ifdef MUX_VARREDURA_EN
    logic [SEL_W-1:0] ponteiro;

    assign sel = Modo ? ponteiro : Controle;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ponteiro <= '0;
        end else if (aceita && Modo) begin
            if (ponteiro == SEL_W'(CANAIS - 1))
                ponteiro <= '0;
            else
                ponteiro <= ponteiro + SEL_W'(1);
        end
    end
`else
    logic modo_unused;

    assign modo_unused = Modo;
    assign sel         = Controle;
`endif

    // Capture stage: selected channel registered on accept
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            resultado_p0 <= '0;
            canal_p0     <= '0;
            vld_p0       <= 1'b0;
            erro_p0      <= 1'b0;
        end else if (aceita) begin
            resultado_p0 <= dado_canal(Entradas, sel);
            canal_p0     <= sel;
            vld_p0       <= 1'b1;
            erro_p0      <= fora_de_faixa(sel);
        end else if (Pronto) begin
            vld_p0 <= 1'b0;
        end
    end

    assign Resultado = resultado_p0;
    assign Canal     = canal_p0;
    assign Valido    = vld_p0;
    assign Erro      = erro_p0;

endmodule

// File: tb/tb_mux_n_registrado.sv
// Directed bench for mux_n_registrado with CANAIS=3 (ch0=FF, ch1=02, ch2=00).
module tb_mux_n_registrado;

    localparam int LARGURA = 8;
    localparam int CANAIS  = 3;
    localparam int SEL_W   = $clog2(CANAIS);

    logic                      Clock;
    logic                      Reset;
    logic [CANAIS*LARGURA-1:0] Entradas;
    logic [SEL_W-1:0]          Controle;
    logic                      Modo;
    logic                      Habilita;
    logic                      Pronto;
    logic [LARGURA-1:0]        Resultado;
    logic [SEL_W-1:0]          Canal;
    logic                      Valido;
    logic                      Erro;

    int n_vec = 0;
    int n_err = 0;

    mux_n_registrado #(.LARGURA(LARGURA), .CANAIS(CANAIS)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Entradas(Entradas),
        .Controle(Controle),
        .Modo(Modo),
        .Habilita(Habilita),
        .Pronto(Pronto),
        .Resultado(Resultado),
        .Canal(Canal),
        .Valido(Valido),
        .Erro(Erro)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] r, input logic [1:0] c,
                           input logic v, input logic e);
        chk({tag, "_res"}, 32'(Resultado), 32'(r));
        chk({tag, "_canal"}, 32'(Canal), 32'(c));
        chk({tag, "_valido"}, 32'(Valido), 32'(v));
        chk({tag, "_erro"}, 32'(Erro), 32'(e));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Entradas = {8'h00, 8'h02, 8'hFF};
        Controle = '0;
        Modo     = 1'b0;
        Habilita = 1'b0;
        Pronto   = 1'b0;
        Reset    = 1'b1;
        #2 Reset = 1'b0;
        #1 chk_all("rst_async", 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("rst_2cyc", 8'h00, 2'd0, 1'b0, 1'b0);
        Reset = 1'b1;

        // direct selection, streaming with Pronto high
        Controle = 2'd1; Habilita = 1'b1; Pronto = 1'b1;
        tick();
        chk_all("dir_ch1", 8'h02, 2'd1, 1'b1, 1'b0);
        Controle = 2'd0;
        tick();
        chk_all("dir_ch0", 8'hFF, 2'd0, 1'b1, 1'b0);
        Controle = 2'd3;
        tick();
        chk_all("dir_oor", 8'h00, 2'd3, 1'b1, 1'b1);

        // stall: Habilita ignored while Valido && !Pronto
        Controle = 2'd2; Pronto = 1'b0;
        tick();
        tick();
        chk_all("dir_stall", 8'h00, 2'd3, 1'b1, 1'b1);

        // consume without new request
        Habilita = 1'b0; Pronto = 1'b1;
        tick();
        chk_all("dir_drain", 8'h00, 2'd3, 1'b0, 1'b1);

        // empty output accepts even with Pronto low
        Habilita = 1'b1; Pronto = 1'b0; Controle = 2'd2;
        tick();
        chk_all("dir_empty_acc", 8'h00, 2'd2, 1'b1, 1'b0);

        // reset mid-handshake clears before the next edge
        Reset = 1'b0;
        #2 chk_all("rst_mid", 8'h00, 2'd0, 1'b0, 1'b0);
        Habilita = 1'b0; Pronto = 1'b1;
        tick();
        Reset = 1'b1;
        tick();
        chk("rst_no_valid", 32'(Valido), 32'd0);

`ifdef MUX_VARREDURA_EN
        // round-robin scan from pointer 0
        Modo = 1'b1; Habilita = 1'b1; Pronto = 1'b1;
        tick();
        chk_all("scan0", 8'hFF, 2'd0, 1'b1, 1'b0);
        tick();
        chk_all("scan1", 8'h02, 2'd1, 1'b1, 1'b0);
        tick();
        chk_all("scan2", 8'h00, 2'd2, 1'b1, 1'b0);
        tick();
        chk_all("scan3", 8'hFF, 2'd0, 1'b1, 1'b0);

        // stall holds sample and pointer
        Pronto = 1'b0;
        Entradas = {8'h00, 8'h55, 8'hFF};
        tick();
        chk_all("scan_stall_a", 8'hFF, 2'd0, 1'b1, 1'b0);
        tick();
        tick();
        chk_all("scan_stall_b", 8'hFF, 2'd0, 1'b1, 1'b0);
        Pronto = 1'b1;
        tick();
        chk_all("scan_resume", 8'h55, 2'd1, 1'b1, 1'b0);

        // direct mode does not disturb the pointer
        Modo = 1'b0; Controle = 2'd0;
        tick();
        chk_all("scan_dir_mix", 8'hFF, 2'd0, 1'b1, 1'b0);
        Modo = 1'b1;
        tick();
        chk_all("scan_cont", 8'h00, 2'd2, 1'b1, 1'b0);

        // reset mid-scan at Canal=2 restarts scan at ch0
        Reset = 1'b0;
        #2 chk_all("scan_rst", 8'h00, 2'd0, 1'b0, 1'b0);
        @(posedge Clock);
        #1 Reset = 1'b1;
        tick();
        chk_all("scan_after_rst", 8'hFF, 2'd0, 1'b1, 1'b0);
`else
        // without scan support Modo is ignored
        Modo = 1'b1; Habilita = 1'b1; Pronto = 1'b1; Controle = 2'd2;
        tick();
        chk_all("nomodo_ch2", 8'h00, 2'd2, 1'b1, 1'b0);
        Controle = 2'd1;
        tick();
        chk_all("nomodo_ch1", 8'h02, 2'd1, 1'b1, 1'b0);
        Pronto = 1'b0; Controle = 2'd0;
        Entradas = {8'h00, 8'h55, 8'hFF};
        tick();
        chk_all("nomodo_stall", 8'h02, 2'd1, 1'b1, 1'b0);
        Pronto = 1'b1;
        tick();
        chk_all("nomodo_resume", 8'hFF, 2'd0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_n_registrado.md
# mux_n_registrado

Parametrised, registered N-channel operand selector for the 8-bit datapath; successor to the fixed 3-channel combinational selectors. Captures one of `CANAIS` inputs per accepted cycle and presents it with a valid/ready handshake. Supports direct selection (`Controle`) and a round-robin scan mode for sequencing register-file reads or debug sampling. Sits between the register bank / immediate sources and the ALU operand latches.

## Interface
- `LARGURA`, 8, bits per channel
- `CANAIS`, 4, number of input channels (≥2, need not be a power of two)
- `SEL_W`, `$clog2(CANAIS)`, select/pointer width (derived localparam)

Ports:
- `Clock`  in  1  single clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Entradas`  in  `CANAIS*LARGURA`  packed channels; channel k = bits `[k*LARGURA +: LARGURA]`
- `Controle`  in  `SEL_W`  channel select, direct mode
- `Modo`  in  1  0 = direct, 1 = round-robin scan
- `Habilita`  in  1  request to capture a sample
- `Pronto`  in  1  consumer ready
- `Resultado`  out  `LARGURA`  registered selected data
- `Canal`  out  `SEL_W`  channel index that produced `Resultado`
- `Valido`  out  1  `Resultado`/`Canal`/`Erro` hold a sample
- `Erro`  out  1  sample came from an out-of-range select

## Operation
- Accept condition: `aceita = Habilita && (!Valido || Pronto)`.
- On `aceita`, source channel `s` = `Controle` (Modo=0) or internal `ponteiro` (Modo=1).
- If `s < CANAIS`: `Resultado` ← channel s, `Erro` ← 0. If `s ≥ CANAIS` (direct only): `Resultado` ← 0, `Erro` ← 1. `Canal` ← s in both cases.
- `Valido`: set on `aceita`; else cleared when `Pronto`; else held.
- While `Valido && !Pronto`: `Resultado`, `Canal`, `Erro`, `ponteiro` frozen; `Habilita` ignored (no overwrite, no pointer advance).
- `ponteiro`: advances only on `aceita` with Modo=1; `CANAIS-1` wraps to 0. Unchanged in direct mode.
- Switching `Modo` does not reset `ponteiro`; scan resumes where it left off.
- Combinational paths input→output: none.

## Timing
- Latency: 1 cycle from accepting edge to `Valido`/`Resultado`.
- Throughput: 1 sample/cycle with `Pronto` held high.
- Reset (`Reset`=0): `Resultado`=0, `Canal`=0, `Valido`=0, `Erro`=0, `ponteiro`=0, immediately and independent of `Clock`. Release is synchronised by the integrator.
- Reset mid-handshake: pending sample discarded; no `Valido` after release until a new accept.
- `Habilita` and `Pronto` in the same cycle with `Valido`=1: old sample consumed, new one captured; `Valido` stays 1.

## Configuration
- `MUX_VARREDURA_EN` defined: round-robin scan mode and `ponteiro` present as described.
- Not defined: `Modo` ignored (port kept, unused); always direct; `ponteiro` logic removed; `Canal` always equals the captured `Controle`.

## Test plan
Bench uses `LARGURA`=8, `CANAIS`=3, ch0=8'hFF, ch1=8'h02, ch2=8'h00.
- Reset asserted low for 2 cycles -> all outputs 0, also mid-cycle assertion clears outputs before next edge.
- Modo=0, Controle=1, Habilita=1, Pronto=1 -> next cycle `Resultado`=8'h02, `Canal`=1, `Valido`=1, `Erro`=0.
- Modo=0, Controle=3 -> `Resultado`=8'h00, `Canal`=3, `Erro`=1, `Valido`=1.
- Modo=1 (macro defined), Habilita=1, Pronto=1 for 4 cycles -> `Canal` 0,1,2,0; `Resultado` FF,02,00,FF.
- Scan with Pronto=0 after first sample, ch1 changed to 8'h55 -> `Resultado` holds 8'hFF, `Canal` 0 for all stall cycles; Pronto=1 -> next sample ch1=8'h55, `Canal`=1.
- Reset pulsed low mid-scan at `Canal`=2 -> outputs 0 immediately; after release, first scan sample is ch0 (8'hFF).
